// File: rtl/video_stream_pkg.sv
// ---------------------------------------------------------------------------
// video_stream_pkg
// Shared types and constants for the test-pattern video transmitter.
//   pattern_e  : pattern selector encoding (h-ramp, v-ramp, checker, frame count)
//   tx_state_e : transmitter FSM states, one-hot
//   CHECKER_SHIFT : coordinate bit that sets checker square size (2**3 = 8 px)
//   FCNT_W     : frame counter width
// ---------------------------------------------------------------------------
package video_stream_pkg;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FCNT  = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } tx_state_e;

    localparam int CHECKER_SHIFT = 3;
    localparam int FCNT_W        = 8;

endpackage

// File: rtl/video_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// video_pattern_tx_if
// Valid/ready pixel stream with start-of-frame (tuser) and end-of-line (tlast).
//   master : drives down_data, down_valid, down_tlast, down_tuser; reads down_ready
//   slave  : the reverse
// ---------------------------------------------------------------------------
interface video_pattern_tx_if #(
    parameter int D_WIDTH = 8
) ();

    logic [D_WIDTH-1:0] down_data;
    logic               down_valid;
    logic               down_tlast;
    logic               down_tuser;
    logic               down_ready;

    modport master (
        output down_data,
        output down_valid,
        output down_tlast,
        output down_tuser,
        input  down_ready
    );

    modport slave (
        input  down_data,
        input  down_valid,
        input  down_tlast,
        input  down_tuser,
        output down_ready
    );

endinterface

// File: rtl/video_pattern_tx_xy_counter.sv
// ---------------------------------------------------------------------------
// video_xy_counter
// Raster position of the next pixel to be loaded into the output register.
//   clk, rst  : clock, synchronous active-low reset
//   clear     : force position back to (0,0)
//   adv       : step to the next pixel, wrapping at H_ACTIVE / V_ACTIVE
//   x, y      : current position
//   line_end  : x is the last pixel of the line
//   frame_end : position is the last pixel of the frame
// ---------------------------------------------------------------------------
module video_xy_counter #(
    parameter int  H_ACTIVE = 640,
    parameter int  V_ACTIVE = 480,
    localparam int X_W      = $clog2(H_ACTIVE),
    localparam int Y_W      = $clog2(V_ACTIVE) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           adv,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_end,
    output logic           frame_end
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    assign line_end  = (x_q == X_LAST);
    assign frame_end = line_end && (y_q == Y_LAST);
    assign x         = x_q;
    assign y         = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (line_end) begin
                x_d = '0;
                y_d = frame_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/video_pattern_tx.sv
// ---------------------------------------------------------------------------
// video_pattern_tx
// Test-pattern frame generator driving a registered valid/ready pixel stream.
//   clk, rst    : clock, synchronous active-low reset
//   start       : one-cycle frame request, ignored while busy
//   continuous  : chain the next frame directly after the last pixel
//   pattern_sel : 0 h-ramp, 1 v-ramp, 2 8x8 checker, 3 solid frame count
//   down        : stream master (data/valid/tlast/tuser out, ready in)
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last pixel of a frame is accepted
//
//   state | meaning
//   IDLE  | no stream activity, waiting for start
//   SEND  | output register holds a valid pixel; advance on each accept
// ---------------------------------------------------------------------------
module video_pattern_tx
    import video_stream_pkg::*;
#(
    parameter int  D_WIDTH  = 8,
    parameter int  H_ACTIVE = 640,
    parameter int  V_ACTIVE = 480,
    localparam int X_W      = $clog2(H_ACTIVE),
    localparam int Y_W      = $clog2(V_ACTIVE) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [1:0]          pattern_sel,
    video_pattern_tx_if.master  down,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;

    logic [1:0]          state_q, state_d;
    pattern_e            pat_q, pat_d;
    logic [D_WIDTH-1:0]  data_q, data_d;
    logic                valid_q, valid_d;
    logic                tlast_q, tlast_d;
    logic                tuser_q, tuser_d;
    logic                last_q, last_d;     // pixel in the output register ends the frame
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                done_q, done_d;

    logic                ld;
    logic                load;
    logic                first;
    logic                cnt_clear;
    logic [X_W-1:0]      cnt_x;
    logic [Y_W-1:0]      cnt_y;
    logic                cnt_line_end;
    logic                cnt_frame_end;
    logic                x_chk, y_chk;
    logic [D_WIDTH-1:0]  fcnt_rep;
    logic [D_WIDTH-1:0]  pix;
    pattern_e            pat_use;

    assign ld = ~valid_q | down.down_ready;

    video_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_xy (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .adv       (load),
        .x         (cnt_x),
        .y         (cnt_y),
        .line_end  (cnt_line_end),
        .frame_end (cnt_frame_end)
    );

    // Narrow rasters never reach the checker bit; treat it as 0 there.
    if (X_W > CHECKER_SHIFT) begin : g_xchk
        assign x_chk = cnt_x[CHECKER_SHIFT];
    end else begin : g_xchk_zero
        assign x_chk = 1'b0;
    end

    if (Y_W > CHECKER_SHIFT) begin : g_ychk
        assign y_chk = cnt_y[CHECKER_SHIFT];
    end else begin : g_ychk_zero
        assign y_chk = 1'b0;
    end

    // Frame count replicated or truncated to the pixel width. fcnt_d is used
    // so the first pixel of a chained frame already shows the new count.
    for (genvar i = 0; i < D_WIDTH; i++) begin : g_fcnt
        assign fcnt_rep[i] = fcnt_d[i % FCNT_W];
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        fcnt_d    = fcnt_q;
        done_d    = 1'b0;
        load      = 1'b0;
        first     = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    first   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ld) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        fcnt_d = fcnt_q + 1'b1;
                        if (continuous) begin
                            load  = 1'b1;
                            first = 1'b1;
                        end else begin
                            valid_d   = 1'b0;
                            state_d   = ST_IDLE;
                            cnt_clear = 1'b1;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pat_d   = pat_q;
        data_d  = data_q;
        tlast_d = tlast_q;
        tuser_d = tuser_q;
        last_d  = last_q;
        pat_use = first ? pattern_e'(pattern_sel) : pat_q;
        case (pat_use)
            PAT_HRAMP: pix = D_WIDTH'(cnt_x);
            PAT_VRAMP: pix = D_WIDTH'(cnt_y);
            PAT_CHECK: pix = {D_WIDTH{x_chk ^ y_chk}};
            PAT_FCNT:  pix = fcnt_rep;
            default:   pix = '0;
        endcase
        if (load) begin
            data_d  = pix;
            tlast_d = cnt_line_end;
            tuser_d = (cnt_x == '0) && (cnt_y == '0);
            last_d  = cnt_frame_end;
            if (first) begin
                pat_d = pattern_e'(pattern_sel);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_HRAMP;
            data_q  <= '0;
            valid_q <= 1'b0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    assign down.down_data  = data_q;
    assign down.down_valid = valid_q;
    assign down.down_tlast = tlast_q;
    assign down.down_tuser = tuser_q;
    assign busy            = (state_q == ST_SEND);
    assign frame_done      = done_q;

endmodule

// File: tb/tb_video_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_tx
// Scoreboard bench: each scenario pushes the beats it expects when it issues
// start, then pops and compares them as the stream presents them.
// Main DUT is 4x3 pixels; a second 16x16 instance covers the checker pattern.
// ---------------------------------------------------------------------------
module tb_video_pattern_tx;

    localparam int DW = 8;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int H2 = 16;
    localparam int V2 = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          tlast;
        logic          tuser;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, continuous, busy, frame_done;
    logic [1:0] pattern_sel;
    logic       start2, continuous2, busy2, frame_done2;
    logic [1:0] pattern_sel2;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    fc      = 0;
    beat_t exp_q[$];
    beat_t exp2_q[$];

    always #5 clk = ~clk;

    video_pattern_tx_if #(.D_WIDTH(DW)) s_if ();
    video_pattern_tx_if #(.D_WIDTH(DW)) s2_if ();

    video_pattern_tx #(.D_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .pattern_sel (pattern_sel),
        .down        (s_if),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    video_pattern_tx #(.D_WIDTH(DW), .H_ACTIVE(H2), .V_ACTIVE(V2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .start       (start2),
        .continuous  (continuous2),
        .pattern_sel (pattern_sel2),
        .down        (s2_if),
        .busy        (busy2),
        .frame_done  (frame_done2)
    );

    function automatic logic [DW-1:0] model_pix(input int pat, input int x, input int y, input int f);
        case (pat)
            0:       return DW'(x);
            1:       return DW'(y);
            2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? {DW{1'b1}} : {DW{1'b0}};
            default: return DW'(f % 256);
        endcase
    endfunction

    task automatic push_frame(input int pat, input int f, input int h, input int v, input bit to2);
        beat_t b;
        for (int y = 0; y < v; y++) begin
            for (int x = 0; x < h; x++) begin
                b.data  = model_pix(pat, x, y, f);
                b.tlast = (x == h - 1);
                b.tuser = (x == 0 && y == 0);
                if (to2) exp2_q.push_back(b);
                else     exp_q.push_back(b);
            end
        end
    endtask

    // Drive one cycle's inputs just after the edge, return at the falling edge.
    task automatic cycle(input logic rdy, input logic st);
        @(posedge clk);
        #1;
        s_if.down_ready = rdy;
        start           = st;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; continuous = 1'b0; pattern_sel = 2'd0; s_if.down_ready = 1'b0;
        start2 = 1'b0; continuous2 = 1'b0; pattern_sel2 = 2'd0; s2_if.down_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({s_if.down_valid, s_if.down_tlast, s_if.down_tuser, busy, frame_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/tlast/tuser/busy/done=%b required 00000",
                     {s_if.down_valid, s_if.down_tlast, s_if.down_tuser, busy, frame_done});
        end
        n_tests++;
        if (s_if.down_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 00", s_if.down_data);
        end
        n_tests++;
        if ({s2_if.down_valid, busy2, frame_done2} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_dut2: valid/busy/done=%b required 000", {s2_if.down_valid, busy2, frame_done2});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        fc = 0;
        exp_q.delete();
    endtask

    task automatic test_continuous();
        int xfers = 0;
        int fd    = 0;
        beat_t obs;
        exp_q.delete();
        pattern_sel = 2'd3;
        continuous  = 1'b1;
        push_frame(3, fc, H, V, 0);
        push_frame(3, fc + 1, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            cycle(1'b1, 1'b0);
            if (xfers == H * V + 2) continuous = 1'b0;
            obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
            n_tests++;
            if (s_if.down_valid !== 1'b1 || obs !== exp_q[0]) begin
                n_fail++;
                $display("FAIL cont_beat%0d: got v=%b d=%h l=%b u=%b required v=1 d=%h l=%b u=%b", xfers,
                         s_if.down_valid, obs.data, obs.tlast, obs.tuser, exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
            end
            if (s_if.down_valid === 1'b1) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            if (frame_done === 1'b1) fd++;
        end
        cycle(1'b1, 1'b0);
        if (frame_done === 1'b1) fd++;
        n_tests++;
        if (fd != 2 || s_if.down_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cont_end: done_pulses=%0d valid=%b busy=%b left=%0d required 2 0 0 0",
                     fd, s_if.down_valid, busy, exp_q.size());
        end
        fc += 2;
    endtask

    task automatic test_basic();
        beat_t obs;
        exp_q.delete();
        continuous  = 1'b0;
        pattern_sel = 2'd0;
        push_frame(0, fc, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < H * V; c++) begin
            cycle(1'b1, 1'b0);
            if (c == 2) pattern_sel = 2'd2;
            obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
            n_tests++;
            if (s_if.down_valid !== 1'b1 || obs !== exp_q[0] || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got v=%b d=%h l=%b u=%b done=%b required v=1 d=%h l=%b u=%b done=0", c,
                         s_if.down_valid, obs.data, obs.tlast, obs.tuser, frame_done,
                         exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
            end
            if (s_if.down_valid === 1'b1) void'(exp_q.pop_front());
        end
        cycle(1'b1, 1'b0);
        n_tests++;
        if ({frame_done, s_if.down_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_end: done/valid/busy=%b required 100", {frame_done, s_if.down_valid, busy});
        end
        cycle(1'b1, 1'b0);
        n_tests++;
        if ({frame_done, s_if.down_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_idle: done/valid/busy=%b required 000", {frame_done, s_if.down_valid, busy});
        end
        fc++;
    endtask

    // rnd=0: fixed 1,0,0,1 ready pattern; rnd=1: random ready.
    task automatic test_backpressure(input int pat, input bit rnd);
        logic rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic rdy;
        int   xfers = 0;
        int   fd    = 0;
        beat_t obs;
        exp_q.delete();
        continuous  = 1'b0;
        pattern_sel = 2'(pat);
        push_frame(pat, fc, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : rp[c % 4];
            cycle(rdy, 1'b0);
            if (s_if.down_valid === 1'b1) begin
                obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
                n_tests++;
                if (obs !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL bp_p%0d_beat%0d: got d=%h l=%b u=%b required d=%h l=%b u=%b", pat, xfers,
                             obs.data, obs.tlast, obs.tuser, exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
                end
                if (rdy) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
            if (frame_done === 1'b1) fd++;
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 1'b0);
            if (frame_done === 1'b1) fd++;
            n_tests++;
            if (s_if.down_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_p%0d_extra: valid=%b d=%h after frame required valid=0", pat, s_if.down_valid, s_if.down_data);
            end
        end
        n_tests++;
        if (xfers != H * V || fd != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_p%0d_count: xfers=%0d done_pulses=%0d busy=%b required %0d 1 0", pat, xfers, fd, busy, H * V);
        end
        fc++;
    endtask

    task automatic test_checker();
        int    xfers = 0;
        beat_t obs;
        exp2_q.delete();
        push_frame(2, 0, H2, V2, 1);
        @(posedge clk);
        #1;
        pattern_sel2 = 2'd2; start2 = 1'b1; s2_if.down_ready = 1'b1;
        for (int c = 0; c < 400 && exp2_q.size() > 0; c++) begin
            @(posedge clk);
            #1 start2 = 1'b0;
            @(negedge clk);
            obs = {s2_if.down_data, s2_if.down_tlast, s2_if.down_tuser};
            if (s2_if.down_valid === 1'b1) begin
                n_tests++;
                if (obs !== exp2_q[0]) begin
                    n_fail++;
                    $display("FAIL checker_beat%0d: got d=%h l=%b u=%b required d=%h l=%b u=%b", xfers,
                             obs.data, obs.tlast, obs.tuser, exp2_q[0].data, exp2_q[0].tlast, exp2_q[0].tuser);
                end
                void'(exp2_q.pop_front());
                xfers++;
            end
        end
        @(negedge clk);
        n_tests++;
        if (xfers != H2 * V2 || {frame_done2, s2_if.down_valid, busy2} !== 3'b100) begin
            n_fail++;
            $display("FAIL checker_end: xfers=%0d done/valid/busy=%b required %0d 100",
                     xfers, {frame_done2, s2_if.down_valid, busy2}, H2 * V2);
        end
    endtask

    task automatic test_reset_mid();
        int    xfers = 0;
        int    fd    = 0;
        beat_t obs;
        exp_q.delete();
        continuous  = 1'b0;
        pattern_sel = 2'd0;
        push_frame(0, fc, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 20 && xfers < 5; c++) begin
            cycle(1'b1, 1'b0);
            if (s_if.down_valid === 1'b1) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            if (frame_done === 1'b1) fd++;
        end
        cycle(1'b0, 1'b0);
        obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
        n_tests++;
        if (s_if.down_valid !== 1'b1 || obs !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rstmid_stall: got v=%b d=%h l=%b u=%b required v=1 d=%h l=%b u=%b",
                     s_if.down_valid, obs.data, obs.tlast, obs.tuser, exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (frame_done === 1'b1) fd++;
        n_tests++;
        if ({s_if.down_valid, busy} !== 2'b00 || fd != 0) begin
            n_fail++;
            $display("FAIL rstmid_abort: valid/busy=%b done_pulses=%0d required 00 0", {s_if.down_valid, busy}, fd);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        fc = 0;
        exp_q.delete();
        pattern_sel = 2'd3;
        push_frame(3, fc, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < H * V; c++) begin
            cycle(1'b1, 1'b0);
            obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
            n_tests++;
            if (s_if.down_valid !== 1'b1 || obs !== exp_q[0]) begin
                n_fail++;
                $display("FAIL rstmid_new%0d: got v=%b d=%h l=%b u=%b required v=1 d=%h l=%b u=%b", c,
                         s_if.down_valid, obs.data, obs.tlast, obs.tuser, exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
            end
            if (s_if.down_valid === 1'b1) void'(exp_q.pop_front());
        end
        cycle(1'b1, 1'b0);
        n_tests++;
        if ({frame_done, s_if.down_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_end: done/valid/busy=%b required 100", {frame_done, s_if.down_valid, busy});
        end
        fc++;
    endtask

    task automatic test_start_ignored();
        int    xfers = 0;
        int    fd    = 0;
        logic  st;
        beat_t obs;
        exp_q.delete();
        continuous  = 1'b0;
        pattern_sel = 2'd1;
        push_frame(1, fc, H, V, 0);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            st = (exp_q.size() == 1) || (c == 3);
            cycle(1'b1, st);
            obs = {s_if.down_data, s_if.down_tlast, s_if.down_tuser};
            n_tests++;
            if (s_if.down_valid !== 1'b1 || obs !== exp_q[0]) begin
                n_fail++;
                $display("FAIL startign_beat%0d: got v=%b d=%h l=%b u=%b required v=1 d=%h l=%b u=%b", xfers,
                         s_if.down_valid, obs.data, obs.tlast, obs.tuser, exp_q[0].data, exp_q[0].tlast, exp_q[0].tuser);
            end
            if (s_if.down_valid === 1'b1) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            if (frame_done === 1'b1) fd++;
        end
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b0);
            if (frame_done === 1'b1) fd++;
            n_tests++;
            if ({s_if.down_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL startign_idle%0d: valid/busy=%b required 00", c, {s_if.down_valid, busy});
            end
        end
        n_tests++;
        if (xfers != H * V || fd != 1) begin
            n_fail++;
            $display("FAIL startign_count: xfers=%0d done_pulses=%0d required %0d 1", xfers, fd, H * V);
        end
        fc++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_basic();
        test_backpressure(0, 1'b0);
        test_backpressure(1, 1'b1);
        test_checker();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_pattern_tx.md
Name: video_pattern_tx

Overview:
- Video stream transmitter: generates one or more test-pattern frames as a valid/ready pixel stream with sideband tuser (start of frame) and tlast (end of line).
- Sits at the upstream end of the downscaler pipeline and drives skid buffers / the downscaler input, both in simulation and on hardware.
- All stream outputs come straight from registers; backpressure is honoured with AXI-stream rules (no data change while valid & ~ready).

Parameters:
- D_WIDTH, 8, pixel data width.
- H_ACTIVE, 640, pixels per line (>=2).
- V_ACTIVE, 480, lines per frame (>=1).
- X_W, $clog2(H_ACTIVE), x counter width (derived, not overridden).
- Y_W, $clog2(V_ACTIVE)+1, y counter width (derived).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next posedge).
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- continuous  in  1  1 = start the next frame back-to-back after the last pixel.
- pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 solid frame-count.
- down_data  out  D_WIDTH  pixel value.
- down_valid  out  1  pixel valid.
- down_tlast  out  1  last pixel of a line.
- down_tuser  out  1  first pixel of a frame.
- down_ready  in  1  sink ready.
- busy  out  1  frame transmission in progress.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset values: down_valid=0, down_tlast=0, down_tuser=0, down_data=0, busy=0, frame_done=0; x=y=0, frame_cnt=0, state=IDLE.
- Reset mid-frame: stream is abandoned and down_valid=0 on the edge after reset. No partial-frame completion and no frame_done.
- Handshake: a beat transfers on posedge when down_valid & down_ready. While down_valid & ~down_ready, all of down_data, down_tlast and down_tuser hold.
- Output register load enable: ld = ~down_valid | down_ready.
- FSM has two states:
  - IDLE: on start, latch pattern_sel into pat_q, load pixel (0,0), assign down_valid=1 and busy=1, then go to SEND. Latency is start at cycle N -> first beat visible at N+1.
  - SEND: on each accepted beat with ld, advance x. At x==H_ACTIVE-1, wrap x to 0 and increment y. The next beat is loaded in the same edge, so there are no bubbles under constant down_ready.
- Sideband: tuser=1 only for (x=0, y=0). tlast=1 when x==H_ACTIVE-1.
- Frame end: when the beat (H_ACTIVE-1, V_ACTIVE-1) is accepted:
  - frame_done pulses and frame_cnt increments (8-bit, wraps 255->0).
  - If continuous==1 at that edge: re-latch pattern_sel and load (0,0) of the next frame with tuser=1 in the same edge; stay in SEND, down_valid stays 1.
  - Otherwise: go to IDLE, down_valid=0, busy=0.
- continuous is sampled only at the last-pixel acceptance. Deasserting it mid-frame lets the current frame finish.
- start arriving in the same cycle as a non-continuous frame end is ignored; the block is still busy that cycle.
- Pattern data, truncated or zero-extended to D_WIDTH:
  - 0: x[D_WIDTH-1:0].
  - 1: y[D_WIDTH-1:0].
  - 2: {D_WIDTH{x[3]^y[3]}} (8x8 checker).
  - 3: frame_cnt replicated or truncated to D_WIDTH.
- pattern_sel changes mid-frame have no effect until the next frame start.

Decomposition:
- Shared package video_stream_pkg:
  - pattern_e enum (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_FCNT).
  - tx_state_e enum (IDLE, SEND), one-hot encoded.
  - CHECKER_SHIFT=3.
- One natural sub-module, video_xy_counter:
  - Inputs: clk, rst, clear, adv.
  - Outputs: x, y, line_end, frame_end.
  - Wraps at H_ACTIVE/V_ACTIVE.
- The top level holds the FSM, the pattern mux and the output register.

Test Plan (H_ACTIVE=4, V_ACTIVE=3, D_WIDTH=8):
- Basic frame: start pulse, pattern 0, down_ready=1 -> 12 beats on consecutive cycles from N+1. Data 0,1,2,3 repeated per line. tuser only on beat 0; tlast on beats 3, 7, 11. frame_done on the edge accepting beat 11, then down_valid=0 and busy=0.
- Backpressure: down_ready toggling 1,0,0,1 pattern -> data, tlast and tuser stable during every stall. Beat order is unchanged, exactly 12 transfers, no duplicates.
- Continuous: continuous=1, pattern 3 -> frame 0 data 0x00, frame 1 data 0x01 with no idle cycle between frames. Deassert continuous during frame 1 -> stop after frame 1 with frame_done pulses = 2.
- Checker/v-ramp: pattern 1 -> lines carry 0, 1, 2. pattern 2 with H_ACTIVE=16, V_ACTIVE=16 -> data 0x00 for x<8 and 0xFF for 8<=x<16 on y<8, inverted for y>=8.
- Reset mid-frame: assert rst=0 at beat 5 while stalled -> next cycle down_valid=0 and busy=0. A new start yields tuser=1 with data 0 (frame_cnt=0).
- start while busy and at frame end (continuous=0) -> ignored; exactly one frame is transmitted.
